// File: rtl/rtc_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler, binary hh:mm:ss and a debounced two-button
// setting interface (mode cycles RUN/SET_HOUR/SET_MIN/SET_SEC, inc bumps the field).
module rtc_time_keeper #(
  parameter int CLK_HZ          = 54_000_000,
  parameter int DEBOUNCE_CYCLES = 540_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] set_mode,
  output logic       tick_1hz
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  mode_t state, state_next;

  logic [PW-1:0] prescaler;
  logic [1:0]    raw, sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] db_cnt [2];
  logic          mode_press, inc_press;

  // Bit 0 carries the mode button, bit 1 the inc button.
  assign raw        = {btn_inc, btn_mode};
  assign mode_press = press[0];
  assign inc_press  = press[1];
  assign set_mode   = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_press) begin
      case (state)
        RUN:      state_next = SET_HOUR;
        SET_HOUR: state_next = SET_MIN;
        SET_MIN:  state_next = SET_SEC;
        default:  state_next = RUN;
      endcase
    end
  end

  // Time only advances in RUN; in the SET states the prescaler sits at zero so the
  // first tick after returning to RUN is a full second later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler <= '0;
      tick_1hz  <= 1'b0;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
    end else begin
      tick_1hz <= 1'b0;
      if (state == RUN) begin
        if (prescaler == PRE_MAX) begin
          prescaler <= '0;
          tick_1hz  <= 1'b1;
          if (sec == 6'd59) begin
            sec <= '0;
            if (min == 6'd59) begin
              min  <= '0;
              hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end else begin
        prescaler <= '0;
        if (inc_press && !mode_press) begin
          case (state)
            SET_HOUR: hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            SET_MIN:  min  <= (min == 6'd59)  ? 6'd0 : min + 6'd1;
            default:  sec  <= (sec == 6'd59)  ? 6'd0 : sec + 6'd1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Bench for rtc_time_keeper: directed and random button/reset stimulus, expected output
// events queued from a seconds-of-day model and checked by an independent monitor.
module tb_rtc_time_keeper;

  localparam int CLK_HZ          = 10;
  localparam int DEBOUNCE_CYCLES = 4;
  // Raw level first sampled on edge c0+1; the resulting state change is visible after edge c0+8.
  localparam int PRESS_LATENCY   = 8;
  localparam int PRESS_WINDOW    = 14;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [1:0] set_mode;
  logic       tick_1hz;

  rtc_time_keeper #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .set_mode(set_mode), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at; int s; int m; int h; int md; int tk;
  } event_t;

  event_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  int m_s = 0, m_m = 0, m_h = 0, m_md = 0, next_tick = 0;
  bit m_run = 1'b1;

  function automatic void advance_second();
    int t;
    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
    m_h = t / 3600;
    m_m = (t / 60) % 60;
    m_s = t % 60;
  endfunction

  function automatic void push_event(input int at, input int tk);
    event_t e;
    e.at = at; e.s = m_s; e.m = m_m; e.h = m_h; e.md = m_md; e.tk = tk;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ticks(input int upto);
    while (m_run && next_tick <= upto) begin
      advance_second();
      push_event(next_tick, 1);
      next_tick += CLK_HZ;
    end
  endfunction

  function automatic int field_value();
    case (m_md)
      1:       return m_h;
      2:       return m_m;
      3:       return m_s;
      default: return -1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int s, input int m, input int h,
                             input int md, input int tk);
    vectors++;
    if (sec !== s || min !== m || hour !== h || set_mode !== md || tick_1hz !== tk) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d:%0d:%0d mode=%0d tick=%0d, expected %0d:%0d:%0d mode=%0d tick=%0d",
               name, hour, min, sec, set_mode, tick_1hz, h, m, s, md, tk);
    end
  endtask

  // Called on a falling edge; raises the selected raw buttons for `hold` cycles.
  task automatic applyStimulus(input bit do_mode, input bit do_inc, input int hold);
    int c0;
    int tk;
    c0 = cyc;
    push_ticks(c0 + PRESS_LATENCY - 1);
    if (hold >= DEBOUNCE_CYCLES) begin
      if (do_mode) begin
        tk = 0;
        if (m_run && next_tick == c0 + PRESS_LATENCY) begin
          advance_second();
          tk = 1;
        end
        m_md  = (m_md + 1) % 4;
        m_run = (m_md == 0);
        if (m_run) next_tick = c0 + PRESS_LATENCY + CLK_HZ;
        push_event(c0 + PRESS_LATENCY, tk);
      end else if (do_inc && m_md != 0) begin
        case (m_md)
          1:       m_h = (m_h + 1) % 24;
          2:       m_m = (m_m + 1) % 60;
          default: m_s = (m_s + 1) % 60;
        endcase
        push_event(c0 + PRESS_LATENCY, 0);
      end
    end
    push_ticks(c0 + PRESS_WINDOW);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (PRESS_WINDOW - hold) @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    push_ticks(cyc + n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse(input int n);
    int c0;
    c0 = cyc;
    push_ticks(c0);
    if (m_s != 0 || m_m != 0 || m_h != 0 || m_md != 0) begin
      m_s = 0; m_m = 0; m_h = 0; m_md = 0;
      push_event(c0 + 1, 0);
    end
    m_run     = 1'b1;
    next_tick = c0 + n + CLK_HZ;
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic inc_to(input int target);
    int guard;
    guard = 0;
    while (field_value() != target && guard < 64) begin
      applyStimulus(1'b0, 1'b1, 6);
      guard++;
    end
  endtask

  // Monitor: any change of time/mode, or a tick, is an output event to be matched in order.
  initial begin
    int p_s, p_m, p_h, p_md;
    event_t e;
    p_s = 0; p_m = 0; p_h = 0; p_md = 0;
    forever begin
      @(negedge clk);
      if (mon_en && (tick_1hz !== 1'b0 || sec !== p_s || min !== p_m ||
                     hour !== p_h || set_mode !== p_md)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_event @%0d: got %0d:%0d:%0d mode=%0d tick=%0d, expected no change",
                   cyc, hour, min, sec, set_mode, tick_1hz);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.at || sec !== e.s || min !== e.m || hour !== e.h ||
              set_mode !== e.md || tick_1hz !== e.tk) begin
            miscompares++;
            $display("[TB] FAIL event: got @%0d %0d:%0d:%0d mode=%0d tick=%0d, expected @%0d %0d:%0d:%0d mode=%0d tick=%0d",
                     cyc, hour, min, sec, set_mode, tick_1hz, e.at, e.h, e.m, e.s, e.md, e.tk);
          end
        end
      end
      p_s = sec; p_m = min; p_h = hour; p_md = set_mode;
    end
  end

  initial begin
    int r, hold;
    bit pick;
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    next_tick = cyc + CLK_HZ;
    checkOutput("reset_state", 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);

    run_cycles(600);

    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("enter_set_hour", m_s, m_m, 0, 1, 0);

    repeat (25) applyStimulus(1'b0, 1'b1, 6);
    checkOutput("hour_25_presses", m_s, m_m, 1, 1, 0);
    inc_to(23);
    applyStimulus(1'b1, 1'b0, 6);
    inc_to(59);

    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("mode_beats_inc", m_s, 59, 23, 3, 0);

    inc_to(59);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("sec_wrap_no_carry", 0, 59, 23, 3, 0);
    inc_to(59);
    run_cycles(200);
    checkOutput("frozen_in_set", 59, 59, 23, 3, 0);

    applyStimulus(1'b1, 1'b0, 6);
    run_cycles(30);

    applyStimulus(1'b1, 1'b0, 6);
    inc_to(12);
    applyStimulus(1'b1, 1'b0, 6);
    inc_to(34);
    applyStimulus(1'b1, 1'b0, 6);
    inc_to(55);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("set_min_12_34_56", 56, 34, 12, 2, 0);
    reset_pulse(1);
    checkOutput("reset_in_set", 0, 0, 0, 0, 0);
    run_cycles(25);

    for (int k = 0; k < 40; k++) begin
      r    = $urandom_range(0, 9);
      hold = $urandom_range(DEBOUNCE_CYCLES, 8);
      pick = 1'($urandom_range(0, 1));
      if (r < 3)       run_cycles($urandom_range(1, 25));
      else if (r < 5)  applyStimulus(1'b1, 1'b0, hold);
      else if (r < 7)  applyStimulus(1'b0, 1'b1, hold);
      else if (r == 7) applyStimulus(1'b1, 1'b1, hold);
      else if (r == 8) applyStimulus(pick, ~pick, 3);
      else             reset_pulse($urandom_range(1, 3));
    end

    run_cycles(20);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
